// File: rtl/bp_nonsynth_io_cmd_responder_if.sv
// Uncached io_cmd/io_resp channel between a host loader (master) and the responder (slave).
// Message layout, MSB first: msg_type, addr, size, payload{lce_id, way_id}, data.
interface bp_nonsynth_io_cmd_responder_if #(
  parameter int msg_width_p = 566
);
  logic [msg_width_p-1:0] io_cmd_i;
  logic                   io_cmd_v_i;
  logic                   io_cmd_yumi_o;
  logic [msg_width_p-1:0] io_resp_o;
  logic                   io_resp_v_o;
  logic                   io_resp_ready_i;

  modport master (
    output io_cmd_i, io_cmd_v_i, io_resp_ready_i,
    input  io_cmd_yumi_o, io_resp_o, io_resp_v_o
  );

  modport slave (
    input  io_cmd_i, io_cmd_v_i, io_resp_ready_i,
    output io_cmd_yumi_o, io_resp_o, io_resp_v_o
  );
endinterface

// File: rtl/bp_nonsynth_io_cmd_responder.sv
// I/O-side endpoint for uncached loader traffic: dword scratchpad plus per-core freeze bits.
// Commands queue in a small FIFO and retire in order into a single response register.
module bp_nonsynth_io_cmd_responder #(
  parameter int paddr_width_p     = 40,
  parameter int cce_block_width_p = 512,
  parameter int lce_id_width_p    = 4,
  parameter int lce_assoc_p       = 8,
  parameter int dword_width_p     = 64,
  parameter int num_core_p        = 2,
  parameter int scratch_els_p     = 1024,
  parameter int fifo_els_p        = 2
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  bp_nonsynth_io_cmd_responder_if.slave io,
  output logic [num_core_p-1:0]     freeze_o,
  output logic                      err_o
);

  localparam int way_w_lp    = (lce_assoc_p > 1) ? $clog2(lce_assoc_p) : 1;
  localparam int dw_bytes_lp = dword_width_p / 8;
  localparam int off_w_lp    = $clog2(dw_bytes_lp);
  localparam int idx_w_lp    = $clog2(scratch_els_p);
  localparam int ptr_w_lp    = $clog2(fifo_els_p);
  localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);

  localparam logic [3:0]  e_cce_mem_uc_rd      = 4'b0010;
  localparam logic [3:0]  e_cce_mem_uc_wr      = 4'b0011;
  localparam logic [3:0]  cfg_dev_gp           = 4'h2;
  localparam logic [19:0] bp_cfg_reg_freeze_gp = 20'h0_0008;

  typedef struct packed {
    logic [lce_id_width_p-1:0] lce_id;
    logic [way_w_lp-1:0]       way_id;
  } payload_s;

  typedef struct packed {
    logic [3:0]               msg_type;
    logic [paddr_width_p-1:0] addr;
    logic [2:0]               size;
    payload_s                 payload;
  } hdr_s;

  typedef struct packed {
    hdr_s                         header;
    logic [cce_block_width_p-1:0] data;
  } msg_s;

  typedef struct packed {
    hdr_s                     header;
    logic [dword_width_p-1:0] data;
  } entry_s;

  typedef struct packed {
    logic [paddr_width_p-32:0] nonlocal;
    logic [6:0]                cce;
    logic [3:0]                dev;
    logic [19:0]               addr;
  } local_addr_s;

  msg_s                  cmd, resp_r, resp_n;
  entry_s                fifo_mem [fifo_els_p];
  entry_s                head;
  logic [ptr_w_lp-1:0]   wptr_r, rptr_r;
  logic [cnt_w_lp-1:0]   cnt_r;
  logic                  full_r, push, exec, resp_v_r, err_r;
  logic [num_core_p-1:0] freeze_r;
  logic                  unused_cmd_data;

  // Zero at time 0 and deliberately untouched by reset so loaded images survive it.
  logic [dword_width_p-1:0] scratch [scratch_els_p] = '{default: '0};

  local_addr_s              la;
  logic [idx_w_lp-1:0]      idx;
  logic [off_w_lp-1:0]      off;
  logic [off_w_lp:0]        nbytes;
  logic                     freeze_hit, is_rd, is_wr, frz_bit;
  logic [dword_width_p-1:0] cur, rd_sh, wr_sh, rd_dw, new_dw;

  assign cmd             = io.io_cmd_i;
  assign unused_cmd_data = ^cmd.data[cce_block_width_p-1:dword_width_p];

  // Full is registered, so a pop in the full cycle does not open a slot until the next one.
  assign push = io.io_cmd_v_i & ~full_r & ~reset_i;
  assign exec = (cnt_r != '0) & (~resp_v_r | io.io_resp_ready_i);

  assign io.io_cmd_yumi_o = push;
  assign io.io_resp_o     = resp_r;
  assign io.io_resp_v_o   = resp_v_r;
  assign freeze_o         = freeze_r;
  assign err_o            = err_r;

  always_comb begin
    head       = fifo_mem[rptr_r];
    la         = head.header.addr;
    idx        = head.header.addr[off_w_lp +: idx_w_lp];
    off        = head.header.addr[off_w_lp-1:0];
    is_rd      = (head.header.msg_type == e_cce_mem_uc_rd);
    is_wr      = (head.header.msg_type == e_cce_mem_uc_wr);
    freeze_hit = (la.nonlocal == '0) && (la.dev == cfg_dev_gp)
              && (la.addr == bp_cfg_reg_freeze_gp) && (int'(la.cce) < num_core_p);

    if (head.header.size >= 3'(off_w_lp)) nbytes = (off_w_lp+1)'(dw_bytes_lp);
    else                                  nbytes = (off_w_lp+1)'(1) << head.header.size;

    cur    = scratch[idx];
    rd_sh  = cur >> {off, 3'b000};
    wr_sh  = head.data << {off, 3'b000};
    new_dw = cur;
    rd_dw  = '0;
    // Bytes past the top of the dword are dropped on write and read back as zero.
    for (int b = 0; b < dw_bytes_lp; b++) begin
      if (b >= int'(off) && b < int'(off) + int'(nbytes)) new_dw[8*b +: 8] = wr_sh[8*b +: 8];
      if (b < int'(nbytes)) rd_dw[8*b +: 8] = rd_sh[8*b +: 8];
    end

    frz_bit = 1'b0;
    for (int i = 0; i < num_core_p; i++)
      if (int'(la.cce) == i) frz_bit = freeze_r[i];

    resp_n        = '0;
    resp_n.header = head.header;
    if (is_rd)
      resp_n.data[dword_width_p-1:0] = freeze_hit ? {{(dword_width_p-1){1'b0}}, frz_bit} : rd_dw;
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wptr_r] <= '{header: cmd.header, data: cmd.data[dword_width_p-1:0]};
    if (exec && is_wr && !freeze_hit) scratch[idx] <= new_dw;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
      full_r <= 1'b0;
    end else begin
      if (push) wptr_r <= (wptr_r == ptr_w_lp'(fifo_els_p-1)) ? '0 : wptr_r + 1'b1;
      if (exec) rptr_r <= (rptr_r == ptr_w_lp'(fifo_els_p-1)) ? '0 : rptr_r + 1'b1;
      case ({push, exec})
        2'b10:   begin cnt_r <= cnt_r + 1'b1; full_r <= (cnt_r + 1'b1 == cnt_w_lp'(fifo_els_p)); end
        2'b01:   begin cnt_r <= cnt_r - 1'b1; full_r <= 1'b0; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      resp_r   <= '0;
      resp_v_r <= 1'b0;
      freeze_r <= '1;
      err_r    <= 1'b0;
    end else begin
      if (exec) begin
        resp_r   <= resp_n;
        resp_v_r <= 1'b1;
      end else if (resp_v_r && io.io_resp_ready_i) begin
        resp_v_r <= 1'b0;
      end
      if (exec && is_wr && freeze_hit)
        for (int i = 0; i < num_core_p; i++)
          if (int'(la.cce) == i) freeze_r[i] <= head.data[0];
      if (exec && !is_rd && !is_wr) err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bp_nonsynth_io_cmd_responder.sv
// Directed bench for bp_nonsynth_io_cmd_responder: freeze bank, sized scratch access,
// wrap/overflow, unsupported commands, backpressure ordering and async reset.
module tb_bp_nonsynth_io_cmd_responder;
  localparam int W  = 566;
  localparam int NC = 2;
  localparam logic [3:0]  WR    = 4'd1;
  localparam logic [3:0]  UC_RD = 4'd2;
  localparam logic [3:0]  UC_WR = 4'd3;
  localparam logic [39:0] FRZ0  = 40'h00_0020_0008;
  localparam logic [39:0] FRZ1  = 40'h00_0120_0008;
  localparam logic [63:0] PAT80 = 64'h1122_3344_BEEF_7788;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic [NC-1:0] freeze_o;
  logic          err_o;
  int            tests = 0;
  int            fails = 0;

  bp_nonsynth_io_cmd_responder_if #(.msg_width_p(W)) io ();

  bp_nonsynth_io_cmd_responder dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .io       (io),
    .freeze_o (freeze_o),
    .err_o    (err_o)
  );

  always #5 clk_i = ~clk_i;

  // Layout: type[565:562] addr[561:522] size[521:519] lce[518:515] way[514:512] data[511:0]
  function automatic logic [W-1:0] mk(input logic [3:0] t, input logic [39:0] a,
                                      input logic [2:0] sz, input logic [3:0] lce,
                                      input logic [63:0] d);
    logic [W-1:0] m;
    m            = '0;
    m[565:562]   = t;
    m[561:522]   = a;
    m[521:519]   = sz;
    m[518:515]   = lce;
    m[514:512]   = 3'd5;
    m[511:64]    = {7{64'hDEAD_BEEF_CAFE_F00D}};
    m[63:0]      = d;
    return m;
  endfunction

  function automatic logic [W-1:0] exp_resp(input logic [W-1:0] c, input logic [63:0] d);
    return {c[W-1:512], 448'b0, d};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_msg(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] m);
    logic ok;
    ok = 1'b0;
    @(negedge clk_i);
    io.io_cmd_i   = m;
    io.io_cmd_v_i = 1'b1;
    for (int n = 0; n < 50 && !ok; n++) begin
      #1 ok = io.io_cmd_yumi_o;
      @(negedge clk_i);
    end
    io.io_cmd_v_i = 1'b0;
    chk("send_accept", 64'(ok), 64'd1);
  endtask

  task automatic recv(output logic [W-1:0] r, output int waits);
    logic got;
    got   = 1'b0;
    r     = '0;
    waits = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk_i);
      io.io_resp_ready_i = 1'b1;
      #1;
      waits = n + 1;
      if (io.io_resp_v_o) begin
        got = 1'b1;
        r   = io.io_resp_o;
      end
    end
    @(negedge clk_i);
    io.io_resp_ready_i = 1'b0;
    chk("recv_valid", 64'(got), 64'd1);
  endtask

  task automatic txn(input string tag, input logic [W-1:0] c, input logic [63:0] d);
    logic [W-1:0] r;
    int           w;
    send(c);
    recv(r, w);
    chk_msg(tag, r, exp_resp(c, d));
  endtask

  initial begin
    logic [W-1:0] r, p, a, b;
    logic [W-1:0] bq [4];
    logic [W-1:0] eq [5];
    int           w, ci, ri;
    logic         saw_v;

    // Reset with a command offered: nothing may be accepted.
    reset_i            = 1'b1;
    io.io_cmd_i        = mk(UC_RD, 40'h80, 3'd3, 4'h0, 64'h0);
    io.io_cmd_v_i      = 1'b1;
    io.io_resp_ready_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_yumi",   64'(io.io_cmd_yumi_o), 64'd0);
    chk("rst_resp_v", 64'(io.io_resp_v_o),   64'd0);
    chk_msg("rst_resp", io.io_resp_o, '0);
    chk("rst_freeze", 64'(freeze_o), 64'h3);
    chk("rst_err",    64'(err_o),    64'd0);
    io.io_cmd_v_i = 1'b0;
    @(negedge clk_i);
    reset_i = 1'b0;

    // Unwritten scratch reads zero.
    txn("zero_init", mk(UC_RD, 40'h200, 3'd3, 4'h1, 64'h0), 64'h0);

    // Freeze clear of core 0; check two-cycle latency and header echo.
    p = mk(UC_WR, FRZ0, 3'd3, 4'h3, 64'h0);
    send(p);
    recv(r, w);
    chk_msg("frz_wr_resp", r, exp_resp(p, 64'h0));
    chk("frz_wr_latency", 64'(w), 64'd1);
    chk("frz_after_clr", 64'(freeze_o), 64'h2);
    txn("frz0_rd", mk(UC_RD, FRZ0, 3'd3, 4'h4, 64'h0), 64'h0);
    txn("frz1_rd", mk(UC_RD, FRZ1, 3'd3, 4'h5, 64'h0), 64'h1);

    // Sized scratch writes merge into one dword.
    txn("s8_wr",  mk(UC_WR, 40'h80, 3'd3, 4'h6, 64'h1122_3344_5566_7788), 64'h0);
    txn("s2_wr",  mk(UC_WR, 40'h82, 3'd1, 4'h7, 64'h0000_0000_0000_BEEF), 64'h0);
    txn("s8_rd",  mk(UC_RD, 40'h80, 3'd3, 4'h8, 64'h0), PAT80);
    txn("s1_rd",  mk(UC_RD, 40'h85, 3'd0, 4'h9, 64'h0), 64'h33);

    // Address wrap and byte overflow past the top of the dword.
    txn("wrap_wr", mk(UC_WR, 40'h2008, 3'd3, 4'hA, 64'h0102_0304_0506_0708), 64'h0);
    txn("wrap_rd", mk(UC_RD, 40'h8,    3'd3, 4'hB, 64'h0), 64'h0102_0304_0506_0708);
    txn("ovf_wr",  mk(UC_WR, 40'hE,    3'd2, 4'hC, 64'h0000_0000_AABB_CCDD), 64'h0);
    txn("ovf_rd8", mk(UC_RD, 40'h8,    3'd3, 4'hD, 64'h0), 64'hCCDD_0304_0506_0708);
    txn("ovf_rd4", mk(UC_RD, 40'hE,    3'd2, 4'hE, 64'h0), 64'h0000_0000_0000_CCDD);

    // Unsupported cached write: zero data, sticky error, no scratch change.
    txn("unsup_resp", mk(WR, 40'h80, 3'd3, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF), 64'h0);
    chk("unsup_err", 64'(err_o), 64'd1);
    txn("unsup_noeff", mk(UC_RD, 40'h80, 3'd3, 4'h1, 64'h0), PAT80);
    chk("err_sticky", 64'(err_o), 64'd1);

    // Backpressure: primer parks in the response register, then 4 back-to-back commands.
    p     = mk(UC_RD, 40'h80, 3'd3, 4'h7, 64'h0);
    bq[0] = mk(UC_WR, 40'h100, 3'd3, 4'h1, 64'hA5);
    bq[1] = mk(UC_RD, 40'h100, 3'd3, 4'h2, 64'h0);
    bq[2] = mk(UC_RD, 40'h81,  3'd0, 4'h3, 64'h0);
    bq[3] = mk(UC_RD, FRZ1,    3'd3, 4'h4, 64'h0);
    eq[0] = exp_resp(p,     PAT80);
    eq[1] = exp_resp(bq[0], 64'h0);
    eq[2] = exp_resp(bq[1], 64'hA5);
    eq[3] = exp_resp(bq[2], 64'h77);
    eq[4] = exp_resp(bq[3], 64'h1);
    send(p);
    ci = 0;
    ri = 0;
    for (int c = 0; c < 60 && ri < 5; c++) begin
      @(negedge clk_i);
      io.io_cmd_v_i = (ci < 4);
      if (ci < 4) io.io_cmd_i = bq[ci];
      io.io_resp_ready_i = (c >= 4);
      #1;
      if (c < 4) begin
        chk("bp_yumi", 64'(io.io_cmd_yumi_o), 64'(c < 2));
        chk("bp_hold_v", 64'(io.io_resp_v_o), 64'd1);
        chk_msg("bp_hold_resp", io.io_resp_o, eq[0]);
      end
      if (io.io_resp_v_o && io.io_resp_ready_i) begin
        chk_msg("bp_order", io.io_resp_o, eq[ri]);
        ri++;
      end
      if (io.io_cmd_yumi_o) ci++;
    end
    @(negedge clk_i);
    io.io_cmd_v_i      = 1'b0;
    io.io_resp_ready_i = 1'b0;
    chk("bp_all_resp", 64'(ri), 64'd5);
    chk("bp_all_cmd",  64'(ci), 64'd4);

    // Async reset mid-cycle with a response pending and a write queued.
    txn("frz_clr2", mk(UC_WR, FRZ0, 3'd3, 4'h2, 64'h0), 64'h0);
    chk("frz_before_rst", 64'(freeze_o), 64'h2);
    a = mk(UC_RD, 40'h80, 3'd3, 4'h5, 64'h0);
    b = mk(UC_WR, 40'h80, 3'd3, 4'h6, 64'h0);
    send(a);
    send(b);
    @(posedge clk_i);
    #3 reset_i = 1'b1;
    #1;
    chk("arst_freeze", 64'(freeze_o), 64'h3);
    chk("arst_resp_v", 64'(io.io_resp_v_o), 64'd0);
    chk("arst_err",    64'(err_o), 64'd0);
    chk_msg("arst_resp", io.io_resp_o, '0);
    @(negedge clk_i);
    reset_i            = 1'b0;
    io.io_resp_ready_i = 1'b1;
    saw_v              = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk_i);
      #1 saw_v = saw_v | io.io_resp_v_o;
    end
    io.io_resp_ready_i = 1'b0;
    chk("arst_flushed", 64'(saw_v), 64'd0);
    txn("scratch_survives", mk(UC_RD, 40'h80, 3'd3, 4'h7, 64'h0), PAT80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
